// File: rtl/mux4_rr_arbiter_pkg.sv
// rtl/mux4_rr_arbiter_pkg.sv - shared constants, state encoding and helpers for the 4:1 round-robin arbiter
package mux4_arb_pkg;

   localparam int N_REQ  = 4;
   localparam int HOLD_W = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // One-hot vector for a 2-bit requester index
   function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// rtl/mux4_rr_arbiter_if.sv - request/data/grant bundle between requesters and the arbiter
interface mux4_rr_arbiter_if #(
   parameter int DW = 1
);
   import mux4_arb_pkg::*;

   logic [N_REQ-1:0]    req;
   logic [N_REQ*DW-1:0] din;
   logic [N_REQ-1:0]    gnt;
   logic [1:0]          sel;
   logic                valid;
   logic [DW-1:0]       dout;

   modport master (
      output req,
      output din,
      input  gnt,
      input  sel,
      input  valid,
      input  dout
   );

   modport slave (
      input  req,
      input  din,
      output gnt,
      output sel,
      output valid,
      output dout
   );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// rtl/mux4_rr_arbiter_rr_pick4.sv - combinational rotating search: first set request at or after start
module rr_pick4
   import mux4_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [1:0]       start,
   output logic             found,
   output logic [1:0]       idx
);

   // Walk offsets from farthest to nearest so the nearest set bit is the last to write idx
   always_comb begin
      found = 1'b0;
      idx   = start;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[start + 2'(k)]) begin
            found = 1'b1;
            idx   = start + 2'(k);
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin grant controller with bounded hold driving a 4:1 data mux
module mux4_rr_arbiter
   import mux4_arb_pkg::*;
#(
   parameter int DW       = 1,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst,
   mux4_rr_arbiter_if.slave  bus
);

   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

   state_e            state_q, state_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [1:0]        sel_q, sel_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;

   logic              idle_found;
   logic [1:0]        idle_idx;
   logic              next_found;
   logic [1:0]        next_idx;
   logic [N_REQ-1:0]  others;
   logic [1:0]        next_start;
   logic              valid;

   // The current holder is masked out so a handoff never re-picks it; it is searched last
   assign others     = bus.req & ~onehot4(sel_q);
   assign next_start = sel_q + 2'd1;

   rr_pick4 u_pick_idle (
      .req   (bus.req),
      .start (ptr_q),
      .found (idle_found),
      .idx   (idle_idx)
   );

   rr_pick4 u_pick_next (
      .req   (others),
      .start (next_start),
      .found (next_found),
      .idx   (next_idx)
   );

   // State register: grant, select, pointer and hold counter all update together
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         sel_q   <= 2'd0;
         hold_q  <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
      end
   end

   // Next-state: start a grant from idle, or continue / hand off / saturate / release while granted
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      hold_d  = hold_q;
      gnt_d   = gnt_q;
      case (state_q)
         IDLE: begin
            if (idle_found) begin
               state_d = GRANT;
               gnt_d   = onehot4(idle_idx);
               sel_d   = idle_idx;
               hold_d  = HOLD_ONE;
               ptr_d   = idle_idx + 2'd1;
            end
         end
         GRANT: begin
            if (!bus.req[sel_q] || (hold_q >= HOLD_MAX)) begin
               // Holder released or used up its slot: pass on if anyone else waits
               if (next_found) begin
                  gnt_d  = onehot4(next_idx);
                  sel_d  = next_idx;
                  hold_d = HOLD_ONE;
                  ptr_d  = next_idx + 2'd1;
               end else if (!bus.req[sel_q]) begin
                  state_d = IDLE;
                  gnt_d   = '0;
               end
            end else begin
               hold_d = hold_q + HOLD_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // Outputs: registered grant/select, valid from state, mux lane picked by the registered select
   always_comb begin
      valid     = (state_q == GRANT);
      bus.gnt   = gnt_q;
      bus.sel   = sel_q;
      bus.valid = valid;
      bus.dout  = valid ? bus.din[sel_q*DW +: DW] : '0;
   end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 data mux among four requesters.
- Accepts per-requester request lines and data, grants one requester at a time, and drives the mux select and the muxed output.
- Enforces a bounded hold time so no requester can starve the others.
- Sits in front of the 4:1 mux datapath as its select controller.

Parameters:
- DW, 1, data width per requester (1 = single-bit mux lanes).
- MAX_HOLD, 4, maximum consecutive cycles a requester keeps the grant while others are waiting; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; req[i] from requester i.
- din  input  4*DW  packed mux inputs; lane i is din[i*DW +: DW].
- gnt  output  4  registered one-hot grant; all zero when idle.
- sel  output  2  registered mux select; equals the index of the granted requester.
- valid  output  1  high while a grant is active.
- dout  output  DW  din lane selected by sel when valid=1; 0 when valid=0 (combinational from sel/din).

Behaviour:
- Reset state:
  - rst=1 at a clock edge forces state=IDLE, gnt=0000, sel=00, valid=0, ptr=0, hold_cnt=0.
  - dout=0 follows from valid=0.
  - Reset overrides any in-progress grant; the grant drops at the next edge.
- State register: ptr, 2 bits, is the search start index, i.e. last winner + 1 mod 4.
- Winner search (rr_pick):
  - Scan req starting at index ptr, wrapping 3→0.
  - The first set bit wins.
  - found=0 if req=0000.
- IDLE:
  - If found, then at the next edge: state=GRANT, gnt=onehot(win), sel=win, valid=1, hold_cnt=1, ptr=win+1.
  - If not found, stay in IDLE.
- Grant latency: a request sampled at edge N appears as gnt at edge N+1. There is no combinational path from req to gnt.
- GRANT, with cur=sel and others = req with bit cur masked:
  - Release (req[cur]=0):
    - If others is non-zero, grant the next winner from the search starting at cur+1 at the same edge. There is no idle bubble; hold_cnt=1.
    - Otherwise go to IDLE: gnt=0, valid=0. sel holds its last value.
  - Continue (req[cur]=1 and hold_cnt<MAX_HOLD): keep the grant; hold_cnt+1.
  - Preempt (req[cur]=1, hold_cnt==MAX_HOLD, others non-zero): grant the next winner from cur+1; hold_cnt=1.
  - Saturate (req[cur]=1, hold_cnt==MAX_HOLD, others=0): keep the grant; hold_cnt stays at MAX_HOLD.
- Round-robin order: every winner change sets ptr=winner+1. A requester that just lost the grant is searched last.
- hold_cnt: 4 bits, saturating, never wraps.
- Grant invariants:
  - gnt is always one-hot or zero.
  - valid equals |gnt.
  - sel matches the set gnt bit whenever valid=1.
- Simultaneous requests: resolved purely by ptr order, with no fixed priority. The first grant after reset with req=1111 goes to requester 0.
- The din lane for a requester may change every cycle. dout tracks it combinationally while that requester is granted.

Decomposition:
- Package mux4_arb_pkg holds:
  - N_REQ=4
  - the state encodings IDLE=1'b0, GRANT=1'b1
  - the hold counter width HOLD_W=4
- Sub-module rr_pick4 is combinational: inputs req[3:0] and start[1:0]; outputs found and idx[1:0]. It is instantiated once for the IDLE search and once for the GRANT search, where the GRANT instance sees req with bit cur masked.
- The data mux is an inline indexed part-select on din. It adds no sequential logic.

Test Plan:
- Reset priority: hold rst=1 for 2 cycles with req=1111 → gnt=0000, valid=0, dout=0; release rst → gnt=0001, sel=00 one cycle later.
- Single requester: req=0100 held for 10 cycles, din lane 2 toggling → gnt=0100 throughout, no preemption (hold_cnt saturates at 4), dout follows din[2*DW +: DW].
- Fairness rotation: req=1111 held constant, MAX_HOLD=4 → grants 0,1,2,3,0 in turn, each lasting exactly 4 cycles, with no gap between grants.
- Release handoff: grant on requester 1; drop req[1] while req=1001 → next edge gnt=1000 (search starts at 2), valid stays 1.
- Idle return and wrap: grant on requester 3; drop all requests → gnt=0000, valid=0, dout=0; then req=0011 → gnt=0001 (ptr wrapped to 0).
- Mid-grant reset: grant on requester 2 with hold_cnt=3; assert rst for 1 cycle → gnt=0000; after release with req=0101 → gnt=0001 (ptr reset to 0).
